// File: rtl/nds_capture_pkg.sv
// Shared capture-path definitions: screen geometry, frame-buffer
// region bases and the write-arbiter state encoding.
package nds_capture_pkg;

    localparam int SCREEN_W          = 256;
    localparam int SCREEN_H          = 192;
    localparam int PIXELS_PER_SCREEN = SCREEN_W * SCREEN_H;

    localparam logic [31:0] DEF_TOP_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_BOT_BASE = 32'h0003_0000;

    typedef enum logic {
        SCR_TOP = 1'b0,
        SCR_BOT = 1'b1
    } screen_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/nds_fb_write_arbiter_if.sv
// AXI4-Lite write-only channel bundle between the frame-buffer
// arbiter (master) and the BRAM controller (slave).
interface nds_fb_write_arbiter_if #(
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_BVALID;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA,
        output S_AXI_WVALID, S_AXI_WSTRB, S_AXI_BREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
        input  S_AXI_BRESP
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA,
        input  S_AXI_WVALID, S_AXI_WSTRB, S_AXI_BREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
        output S_AXI_BRESP
    );

endinterface

// File: rtl/nds_rr_arb2.sv
// Two-way round-robin grant; on contention the requester that did
// not win last time is chosen.
module nds_rr_arb2
    import nds_capture_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       take,
    output logic       any,
    output screen_e    grant
);

    logic last_grant_q;
    logic last_grant_d;

    assign any = |req_valid;

    always_comb begin
        grant = SCR_TOP;
        unique case (req_valid)
            2'b01:   grant = SCR_TOP;
            2'b10:   grant = SCR_BOT;
            2'b11:   grant = screen_e'(~last_grant_q);
            default: grant = SCR_TOP;
        endcase
        last_grant_d = last_grant_q;
        if (take && any)
            last_grant_d = grant;
    end

    // Reset to bottom so the top screen wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant_q <= 1'b1;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/nds_fb_write_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite write port between the
// top and bottom screen pixel writers, one AW/W/B burst per pixel.
module nds_fb_write_arbiter
    import nds_capture_pkg::*;
#(
    parameter int          ADDR_W            = 32,
    parameter int          IDX_W             = 16,
    parameter int          PIXELS_PER_SCREEN = nds_capture_pkg::PIXELS_PER_SCREEN,
    parameter logic [31:0] TOP_BASE          = nds_capture_pkg::DEF_TOP_BASE,
    parameter logic [31:0] BOT_BASE          = nds_capture_pkg::DEF_BOT_BASE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [IDX_W-1:0]       req_idx_top,
    input  logic [IDX_W-1:0]       req_idx_bot,
    input  logic [31:0]            req_data_top,
    input  logic [31:0]            req_data_bot,
    nds_fb_write_arbiter_if.master axi,
    output logic                   busy,
    output logic                   slv_err,
    output logic [7:0]             drop_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              slv_err_q, slv_err_d;
    logic [7:0]        drop_q, drop_d;

    logic              idle;
    logic              any;
    screen_e           grant;
    logic [IDX_W-1:0]  sel_idx;
    logic [31:0]       sel_data;
    logic [ADDR_W-1:0] sel_base;
    logic              in_range;

    assign idle = (state_q == ST_IDLE);

    nds_rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .take      (idle),
        .any       (any),
        .grant     (grant)
    );

    assign sel_idx  = (grant == SCR_BOT) ? req_idx_bot : req_idx_top;
    assign sel_data = (grant == SCR_BOT) ? req_data_bot : req_data_top;
    assign sel_base = (grant == SCR_BOT) ? ADDR_W'(BOT_BASE)
                                         : ADDR_W'(TOP_BASE);
    assign in_range = ADDR_W'(sel_idx) < ADDR_W'(PIXELS_PER_SCREEN);

    assign req_ready = !(idle && any) ? 2'b00
                     : (grant == SCR_BOT) ? 2'b10 : 2'b01;

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        slv_err_d = slv_err_q;
        drop_d    = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    if (!in_range) begin
                        if (drop_q != 8'hFF)
                            drop_d = drop_q + 8'd1;
                    end else begin
                        awaddr_d  = sel_base + (ADDR_W'(sel_idx) << 2);
                        wdata_d   = sel_data;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W complete independently, in any order.
                if (awvalid_q && axi.S_AXI_AWREADY)
                    awvalid_d = 1'b0;
                if (wvalid_q && axi.S_AXI_WREADY)
                    wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                if (axi.S_AXI_BVALID) begin
                    state_d = ST_IDLE;
                    if (axi.S_AXI_BRESP != 2'b00)
                        slv_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            slv_err_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            slv_err_q <= slv_err_d;
            drop_q    <= drop_d;
        end
    end

    assign axi.S_AXI_AWADDR  = awaddr_q;
    assign axi.S_AXI_AWVALID = awvalid_q;
    assign axi.S_AXI_WDATA   = wdata_q;
    assign axi.S_AXI_WVALID  = wvalid_q;
    assign axi.S_AXI_WSTRB   = 4'b1111;
    assign axi.S_AXI_BREADY  = (state_q == ST_RESP);

    assign busy       = !idle;
    assign slv_err    = slv_err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_nds_fb_write_arbiter.sv
// Bench for the frame-buffer write arbiter: request vector table,
// AXI slave model with programmable stalls, address/data scoreboard.
module tb_nds_fb_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_idx_top, req_idx_bot;
    logic [31:0] req_data_top, req_data_bot;
    logic        busy, slv_err;
    logic [7:0]  drop_count;

    nds_fb_write_arbiter_if #(.ADDR_W(32)) axi ();

    nds_fb_write_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_idx_top  (req_idx_top),
        .req_idx_bot  (req_idx_bot),
        .req_data_top (req_data_top),
        .req_data_bot (req_data_bot),
        .axi          (axi),
        .busy         (busy),
        .slv_err      (slv_err),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    // Slave model: programmable AW/W stall, response one cycle after BREADY.
    int         aw_delay = 0;
    int         w_delay  = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int         aw_cnt = 0;
    int         w_cnt  = 0;

    initial begin
        axi.S_AXI_AWREADY = 1'b0;
        axi.S_AXI_WREADY  = 1'b0;
        axi.S_AXI_BVALID  = 1'b0;
        axi.S_AXI_BRESP   = 2'b00;
    end

    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            axi.S_AXI_AWREADY = 1'b0;
            axi.S_AXI_WREADY  = 1'b0;
            axi.S_AXI_BVALID  = 1'b0;
            aw_cnt = 0;
            w_cnt  = 0;
        end else begin
            axi.S_AXI_AWREADY = axi.S_AXI_AWVALID && (aw_cnt == aw_delay);
            aw_cnt = axi.S_AXI_AWVALID ? aw_cnt + 1 : 0;
            axi.S_AXI_WREADY = axi.S_AXI_WVALID && (w_cnt == w_delay);
            w_cnt = axi.S_AXI_WVALID ? w_cnt + 1 : 0;
            axi.S_AXI_BVALID = axi.S_AXI_BREADY;
            axi.S_AXI_BRESP  = bresp_cfg;
        end
    end

    // Monitor on the falling edge: push accepted requests, pop completed writes.
    logic        aw_got, w_got, hold_v;
    logic [31:0] got_addr, got_data, hold_addr;
    int          aw_hi, w_hi, overlap;

    initial begin
        aw_got = 0; w_got = 0; hold_v = 0;
        got_addr = 0; got_data = 0; hold_addr = 0;
        aw_hi = 0; w_hi = 0; overlap = 0;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            aw_got = 0;
            w_got  = 0;
            hold_v = 0;
        end else begin
            if (axi.S_AXI_AWVALID) begin
                aw_hi++;
                if (hold_v)
                    chk("awaddr_stable", axi.S_AXI_AWADDR, hold_addr);
                hold_addr = axi.S_AXI_AWADDR;
                hold_v = 1;
            end else begin
                hold_v = 0;
            end
            if (axi.S_AXI_WVALID)
                w_hi++;
            if (axi.S_AXI_BREADY && axi.S_AXI_AWVALID)
                overlap++;
            if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) begin
                aw_got = 1;
                got_addr = axi.S_AXI_AWADDR;
            end
            if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) begin
                w_got = 1;
                got_data = axi.S_AXI_WDATA;
            end
            if (aw_got && w_got) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: addr %0h data %0h",
                             got_addr, got_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_awaddr", got_addr, e.addr);
                    chk("sb_wdata", got_data, e.data);
                end
                aw_got = 0;
                w_got  = 0;
            end
            if (req_valid[0] && req_ready[0] && req_idx_top < 16'd49152)
                sb.push_back({32'h0000_0000 + 32'(req_idx_top) * 4,
                              req_data_top});
            if (req_valid[1] && req_ready[1] && req_idx_bot < 16'd49152)
                sb.push_back({32'h0003_0000 + 32'(req_idx_bot) * 4,
                              req_data_bot});
        end
    end

    // Present one request pattern, check the grant and cycles back to idle.
    task automatic run_req(input logic [1:0] v, input logic [15:0] it,
                           input logic [15:0] ib, input logic [31:0] dt,
                           input logic [31:0] db, input logic [1:0] rdy,
                           input int lat_exp);
        int lat;
        req_valid    = v;
        req_idx_top  = it;
        req_idx_bot  = ib;
        req_data_top = dt;
        req_data_bot = db;
        #1;
        chk("req_ready", req_ready, rdy);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        lat = 1;
        while (busy && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, lat_exp);
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [15:0] it;
        logic [15:0] ib;
        logic [31:0] dt;
        logic [31:0] db;
        logic [1:0]  rdy;
        int          lat;
        logic [7:0]  drops;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'b01, 16'd0,     16'd0,     32'h00AB_CDEF, 32'h0,         2'b01, 3, 8'd0};
        vecs[1] = '{2'b10, 16'd0,     16'd5,     32'h0,         32'h0011_2233, 2'b10, 3, 8'd0};
        vecs[2] = '{2'b11, 16'd1,     16'd5,     32'hA000_0001, 32'hB000_0005, 2'b01, 3, 8'd0};
        vecs[3] = '{2'b11, 16'd2,     16'd5,     32'hA000_0002, 32'hB000_0005, 2'b10, 3, 8'd0};
        vecs[4] = '{2'b11, 16'd3,     16'd5,     32'hA000_0003, 32'hB000_0006, 2'b01, 3, 8'd0};
        vecs[5] = '{2'b01, 16'd49152, 16'd0,     32'hDEAD_BEEF, 32'h0,         2'b01, 1, 8'd1};
        vecs[6] = '{2'b10, 16'd0,     16'd49151, 32'h0,         32'h00FF_00FF, 2'b10, 3, 8'd1};
        vecs[7] = '{2'b01, 16'd49151, 16'd0,     32'h0012_3456, 32'h0,         2'b01, 3, 8'd1};
        vecs[8] = '{2'b10, 16'd0,     16'hFFFF,  32'h0,         32'hCAFE_F00D, 2'b10, 1, 8'd2};
        vecs[9] = '{2'b11, 16'd100,   16'd200,   32'h0000_0100, 32'h0000_0200, 2'b01, 3, 8'd2};

        reset_n      = 1'b0;
        req_valid    = 2'b00;
        req_idx_top  = '0;
        req_idx_bot  = '0;
        req_data_top = '0;
        req_data_bot = '0;
        #12;
        chk("rst_awvalid", axi.S_AXI_AWVALID, 0);
        chk("rst_wvalid", axi.S_AXI_WVALID, 0);
        chk("rst_bready", axi.S_AXI_BREADY, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_awaddr", axi.S_AXI_AWADDR, 0);
        chk("rst_wdata", axi.S_AXI_WDATA, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slv_err", slv_err, 0);
        chk("rst_drop", drop_count, 0);
        chk("wstrb", axi.S_AXI_WSTRB, 4'hF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].v, vecs[i].it, vecs[i].ib, vecs[i].dt,
                    vecs[i].db, vecs[i].rdy, vecs[i].lat);
            chk("drop_count", drop_count, vecs[i].drops);
        end

        // AW stalled three cycles, W accepted at once.
        aw_delay = 3;
        aw_hi = 0;
        w_hi = 0;
        overlap = 0;
        run_req(2'b01, 16'd7, 16'd0, 32'h7777_0007, 32'h0, 2'b01, 6);
        chk("aw_valid_cycles", aw_hi, 4);
        chk("w_valid_cycles", w_hi, 1);
        chk("resp_before_aw", overlap, 0);
        aw_delay = 0;

        // Error response is sticky across later OKAY responses.
        bresp_cfg = 2'b10;
        run_req(2'b10, 16'd0, 16'd1, 32'h0, 32'h5151_0001, 2'b10, 3);
        chk("slv_err_set", slv_err, 1);
        bresp_cfg = 2'b00;
        run_req(2'b01, 16'd2, 16'd0, 32'h5252_0002, 32'h0, 2'b01, 3);
        chk("slv_err_sticky", slv_err, 1);

        // Out-of-range flood saturates the drop counter.
        req_idx_top = 16'd49152;
        req_valid = 2'b01;
        repeat (300) @(posedge clk);
        #1;
        req_valid = 2'b00;
        chk("drop_saturate", drop_count, 8'd255);
        chk("drop_idle", busy, 0);

        // Asynchronous reset while AW and W are both stalled.
        aw_delay = 5;
        w_delay  = 5;
        req_idx_top  = 16'd3;
        req_data_top = 32'h0BAD_0003;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #3;
        chk("pre_rst_awvalid", axi.S_AXI_AWVALID, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", axi.S_AXI_AWVALID, 0);
        chk("mid_rst_wvalid", axi.S_AXI_WVALID, 0);
        chk("mid_rst_bready", axi.S_AXI_BREADY, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_slv_err", slv_err, 0);
        chk("mid_rst_drop", drop_count, 0);
        aw_delay = 0;
        w_delay  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_req(2'b11, 16'd10, 16'd20, 32'h1010_1010, 32'h2020_2020, 2'b01, 3);
        run_req(2'b11, 16'd11, 16'd21, 32'h1111_1111, 32'h2121_2121, 2'b10, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1);
    end

endmodule
